// File: rtl/inv_bist_if.sv
// inv_bist_if: start/result bundle between the BIST engine and its host,
// plus the stimulus/response pair to the unit under test.
interface inv_bist_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [WIDTH-1:0] fail_vec;

    modport master (
        input  start,
        input  dut_y,
        output dut_a,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec
    );

    modport slave (
        output start,
        output dut_y,
        input  dut_a,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec
    );
endinterface

// File: rtl/inv_bist.sv
// inv_bist: exhaustive sweep of an inverter-class unit, checks y == ~a.
// Optional macro INV_BIST_STOP_ON_FAIL_EN ends the sweep on the first miss.
module inv_bist #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    inv_bist_if.master  bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_S,
        CHECK,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             first_fail;
    logic             miss;
    logic             last;
    logic [CNT_W-1:0] err_nxt;

    // Response check and saturating next error count.
    always_comb begin
        miss    = (bus.dut_y != ~bus.dut_a);
        last    = (bus.dut_a == '1);
        err_nxt = bus.err_count;
        if (miss && (bus.err_count != '1))
            err_nxt = bus.err_count + CNT_W'(1);
    end

    // Sweep FSM with registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            first_fail    <= 1'b0;
            bus.dut_a     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= '0;
            bus.fail_vec  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state         <= SETTLE_S;
                        cnt           <= CW'(SETTLE - 1);
                        first_fail    <= 1'b0;
                        bus.dut_a     <= '0;
                        bus.busy      <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.pass      <= 1'b0;
                        bus.err_count <= '0;
                        bus.fail_vec  <= '0;
                    end
                end
                SETTLE_S: begin
                    if (cnt != '0)
                        cnt <= cnt - CW'(1);
                    else
                        state <= CHECK;
                end
                CHECK: begin
                    bus.err_count <= err_nxt;
                    if (miss && !first_fail) begin
                        bus.fail_vec <= bus.dut_a;
                        first_fail   <= 1'b1;
                    end
`ifdef INV_BIST_STOP_ON_FAIL_EN
                    if (last || miss) begin
`else
                    if (last) begin
`endif
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= (err_nxt == '0);
                    end else begin
                        state     <= SETTLE_S;
                        cnt       <= CW'(SETTLE - 1);
                        bus.dut_a <= bus.dut_a + WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_bist.sv
// tb_inv_bist: directed checks of inv_bist with golden, stuck-at-0 and
// stuck-at-1 units, held start, and asynchronous reset mid-sweep.
module tb_inv_bist;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    int         n_tests = 0;
    int         n_fail  = 0;

    inv_bist_if #(.WIDTH(1), .CNT_W(8)) bus ();

    inv_bist #(
        .WIDTH  (1),
        .SETTLE (2),
        .CNT_W  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Unit under test model: golden inverter or stuck output.
    assign bus.dut_y = (mode == 2'd0) ? ~bus.dut_a :
                       (mode == 2'd1) ? 1'b0 : 1'b1;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse start so that the next edge (E) samples it; returns after E.
    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        mode      = 2'd0;
        tick(2);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err_count, 0);
        chk("rst_fvec", bus.fail_vec, 0);
        chk("rst_a", bus.dut_a, 0);
        reset = 1'b0;
        tick(1);

        // Golden sweep: busy after E..E+5, done after E+6.
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("gold_busy_%0d", k), bus.busy, 1);
            chk($sformatf("gold_ndone_%0d", k), bus.done, 0);
            if (k < 5) tick(1);
        end
        tick(1);
        chk("gold_done", bus.done, 1);
        chk("gold_busy_off", bus.busy, 0);
        chk("gold_pass", bus.pass, 1);
        chk("gold_err", bus.err_count, 0);
        chk("gold_a", bus.dut_a, 1);

        // Stuck-at-0, restarted from DONE.
        mode = 2'd1;
        pulse_start();
        chk("s0_restart_done", bus.done, 0);
        chk("s0_restart_pass", bus.pass, 0);
`ifdef INV_BIST_STOP_ON_FAIL_EN
        tick(2);
        chk("s0_ndone_e2", bus.done, 0);
        tick(1);
        chk("s0_done_e3", bus.done, 1);
        chk("s0_a", bus.dut_a, 0);
`else
        tick(5);
        chk("s0_ndone_e5", bus.done, 0);
        tick(1);
        chk("s0_done_e6", bus.done, 1);
        chk("s0_fvec", bus.fail_vec, 0);
`endif
        chk("s0_pass", bus.pass, 0);
        chk("s0_err", bus.err_count, 1);

        // Stuck-at-1: only vector 1 fails.
        mode = 2'd2;
        pulse_start();
        tick(6);
        chk("s1_done", bus.done, 1);
        chk("s1_pass", bus.pass, 0);
        chk("s1_err", bus.err_count, 1);
        chk("s1_fvec", bus.fail_vec, 1);

        // Start held E..E+10: restart from DONE at E+7, ignored while busy.
        mode      = 2'd0;
        bus.start = 1'b1;
        tick(7);
        chk("hold_done_e6", bus.done, 1);
        chk("hold_pass_e6", bus.pass, 1);
        tick(1);
        chk("hold_done_e7", bus.done, 0);
        chk("hold_busy_e7", bus.busy, 1);
        tick(3);
        bus.start = 1'b0;
        tick(2);
        chk("hold_ndone_e12", bus.done, 0);
        tick(1);
        chk("hold_done_e13", bus.done, 1);
        tick(1);
        chk("hold_stay_e14", bus.done, 1);

        // Asynchronous reset mid-sweep, then a fresh run.
        mode = 2'd1;
        pulse_start();
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_err", bus.err_count, 0);
        chk("arst_a", bus.dut_a, 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            if (bus.done) break;
            tick(1);
        end
        chk("arst_redone", bus.done, 1);
        chk("arst_reerr", bus.err_count, 1);
        chk("arst_repass", bus.pass, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
